// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified instruction/data memory arbiter:
// default memory geometry and the encodings of the read-return owner register.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 6;
    localparam int unsigned MEM_DATA_W = 32;

    typedef logic [1:0] owner_t;

    // Which requester the memory read data returning this cycle belongs to
    localparam owner_t OWN_IDLE = 2'd0;
    localparam owner_t OWN_IF   = 2'd1;
    localparam owner_t OWN_D    = 2'd2;

endpackage

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating counter of consecutive cycles in which fetch was denied.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   i_inc  in   increment request (ignored once saturated)
//   i_clr  in   clear request (wins over i_inc)
//   o_sat  out  count has reached MAX
// -----------------------------------------------------------------------------
module arb_starve_cnt #(
    parameter int unsigned MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_port_arbiter
// Shares one single-port synchronous-read memory between instruction fetch
// and load/store. One grant per cycle; data has priority except when fetch
// has been denied STARVE_MAX cycles in a row. Read data returns one cycle
// after the grant and is steered to the granted requester.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request and word address
//   if_gnt                     fetch granted this cycle (combinational)
//   if_rvalid/if_rdata         fetch return; data held until next return
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_gnt                      data granted this cycle (combinational)
//   d_rvalid/d_rdata           load return; data held until next return
//   mem_addr/mem_we/mem_wdata  memory command side
//   mem_rdata                  memory read data, valid cycle after mem_addr
//   stall                      a request was denied this cycle
// -----------------------------------------------------------------------------
module imem_dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    logic              w_sat;
    logic              w_force_if;
    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (if_req & ~if_gnt),
        .i_clr (if_gnt | ~if_req),
        .o_sat (w_sat)
    );

    // Grant
    assign w_force_if = w_sat & if_req;
    assign d_gnt      = d_req & ~w_force_if;
    assign if_gnt     = if_req & ~d_gnt;
    assign stall      = (if_req & ~if_gnt) | (d_req & ~d_gnt);

    // Memory command mux; with no grant the last issued address is held
    always_comb begin
        mem_addr = r_mem_addr;
        if (d_gnt) begin
            mem_addr = d_addr;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // Write enable is gated by reset so no store lands while the core is held
    assign mem_we    = d_gnt & d_we & rst_n;
    assign mem_wdata = d_wdata;

    always_comb begin
        w_owner_nxt = OWN_IDLE;
        if (if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_IDLE;
            r_mem_addr <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_mem_addr <= mem_addr;
            if (r_owner == OWN_IF) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_owner == OWN_D) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    // Return data passes straight through in the return cycle and is then
    // held by the capture register, so it is valid together with rvalid.
    assign if_rvalid = (r_owner == OWN_IF);
    assign d_rvalid  = (r_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata   = d_rvalid  ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_dmem_port_arbiter
// Directed bench for the fetch/data memory arbiter. A behavioural 64x32
// synchronous memory sits on the memory port; a separate reference array
// predicts read data. Expected return words are queued when a grant is
// expected and consumed when the matching rvalid appears.
// -----------------------------------------------------------------------------
module tb_imem_dmem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] q_if [$];
    logic [DW-1:0] q_d  [$];

    imem_dmem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Return monitor: sampled mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (if_rvalid === 1'b1) begin
            if (q_if.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, '0);
            else                  chk("if_rdata", if_rdata, q_if.pop_front());
        end
        if (d_rvalid === 1'b1) begin
            if (q_d.size() == 0) chk("d_rvalid_unexpected", {31'b0, d_rvalid}, '0);
            else                 chk("d_rdata", d_rdata, q_d.pop_front());
        end
    end

    // Drive one cycle's requests just after the rising edge
    task automatic drive(input logic fi, input logic [AW-1:0] fa,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] dd);
        @(posedge clk);
        #1;
        if_req  = fi;
        if_addr = fa;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        #2;
    endtask

    task automatic chk_gnt(input string tag, input logic eif, input logic ed, input logic est);
        chk({tag, "_if_gnt"}, {31'b0, if_gnt}, {31'b0, eif});
        chk({tag, "_d_gnt"},  {31'b0, d_gnt},  {31'b0, ed});
        chk({tag, "_stall"},  {31'b0, stall},  {31'b0, est});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i) * 32'h0001_0111;
            ref_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0111;
        end
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state
        #13;
        chk("rst_if_rvalid", {31'b0, if_rvalid}, '0);
        chk("rst_d_rvalid",  {31'b0, d_rvalid},  '0);
        chk("rst_if_rdata",  if_rdata, '0);
        chk("rst_d_rdata",   d_rdata,  '0);
        chk("rst_mem_addr",  {26'b0, mem_addr}, '0);
        chk("rst_stall",     {31'b0, stall}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: fetch only, addresses 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
            chk_gnt("fetch", 1'b1, 1'b0, 1'b0);
            chk("fetch_mem_addr", {26'b0, mem_addr}, 32'(i));
            chk("fetch_mem_we", {31'b0, mem_we}, '0);
            q_if.push_back(ref_mem[i]);
        end

        // 6: idle, address holds at last fetch
        drive(1'b0, 6'd20, 1'b0, 1'b0, 6'd21, '0);
        chk_gnt("idle", 1'b0, 1'b0, 1'b0);
        chk("idle_mem_we", {31'b0, mem_we}, '0);
        chk("idle_mem_addr", {26'b0, mem_addr}, 32'd3);

        // 2: load and fetch in the same cycle
        drive(1'b1, 6'd5, 1'b1, 1'b0, 6'd2, '0);
        chk_gnt("conflict", 1'b0, 1'b1, 1'b1);
        chk("conflict_mem_addr", {26'b0, mem_addr}, 32'd2);
        q_d.push_back(ref_mem[2]);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // 3: store 34 to addr 3, then load it back
        drive(1'b0, '0, 1'b1, 1'b1, 6'd3, 32'd34);
        chk_gnt("store", 1'b0, 1'b1, 1'b0);
        chk("store_mem_we", {31'b0, mem_we}, 32'd1);
        chk("store_mem_addr", {26'b0, mem_addr}, 32'd3);
        chk("store_mem_wdata", mem_wdata, 32'd34);
        ref_mem[3] = 32'd34;
        drive(1'b0, '0, 1'b1, 1'b0, 6'd3, '0);
        chk_gnt("load", 1'b0, 1'b1, 1'b0);
        chk("load_mem_we", {31'b0, mem_we}, '0);
        q_d.push_back(ref_mem[3]);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // 4: starvation under continuous data traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd7, 1'b1, 1'b0, AW'(10 + i), '0);
            chk_gnt("starve_deny", 1'b0, 1'b1, 1'b1);
            q_d.push_back(ref_mem[10 + i]);
        end
        drive(1'b1, 6'd7, 1'b1, 1'b0, 6'd13, '0);
        chk_gnt("starve_force", 1'b1, 1'b0, 1'b1);
        chk("starve_mem_addr", {26'b0, mem_addr}, 32'd7);
        q_if.push_back(ref_mem[7]);
        drive(1'b1, 6'd8, 1'b1, 1'b0, 6'd13, '0);
        chk_gnt("starve_cleared", 1'b0, 1'b1, 1'b1);
        q_d.push_back(ref_mem[13]);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // 5: reset while a fetch return is in flight
        drive(1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
        chk_gnt("pre_rst", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = 6'd9;
        q_if.delete();
        #2;
        chk("midrst_if_rvalid", {31'b0, if_rvalid}, '0);
        chk("midrst_if_rdata",  if_rdata, '0);
        chk("midrst_d_rdata",   d_rdata, '0);
        chk("midrst_d_gnt",     {31'b0, d_gnt}, 32'd1);
        chk("midrst_mem_we",    {31'b0, mem_we}, '0);
        @(posedge clk);
        #1 d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
        chk_gnt("post_rst", 1'b1, 1'b0, 1'b0);
        q_if.push_back(ref_mem[9]);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("post_rst_hold_addr", {26'b0, mem_addr}, 32'd9);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        chk("if_queue_drained", 32'(q_if.size()), '0);
        chk("d_queue_drained",  32'(q_d.size()),  '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
